// File: rtl/life_pkg.sv
// Shared types and constants for the life grid controller.
package life_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CALC,
    ST_UPDATE
  } life_state_e;

  typedef enum logic [1:0] {
    PAT_STRIPES  = 2'd0,
    PAT_CLEAR    = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_EXTERNAL = 2'd3
  } life_pat_e;

  localparam int unsigned LIFE_CELL_W_DEF = 2;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/life_seed_gen.sv
// Combinational seed value for one grid cell.
module life_seed_gen
  import life_pkg::*;
#(
  parameter int unsigned P_PARAM_N = 16,
  parameter int unsigned P_PARAM_M = 16,
  parameter int unsigned P_CELL_W  = LIFE_CELL_W_DEF
) (
  input  logic [clog2_min1(P_PARAM_M)-1:0]        row_i,
  input  logic [clog2_min1(P_PARAM_N)-1:0]        col_i,
  input  life_pat_e                               pattern_i,
  input  logic [P_PARAM_N*P_PARAM_M*P_CELL_W-1:0] seed_status_i,
  output logic [P_CELL_W-1:0]                     cell_o
);

  localparam int unsigned COL_A = P_PARAM_N / 3;
  localparam int unsigned COL_B = (2 * P_PARAM_N) / 3;

  logic [31:0] row_u;
  logic [31:0] col_u;
  logic [31:0] off_u;

  assign row_u = 32'(row_i);
  assign col_u = 32'(col_i);
  assign off_u = (row_u * P_PARAM_N + col_u) * P_CELL_W;

  // Pattern decode; checkerboard parity of (r+c) is the XOR of the LSBs.
  always_comb begin
    cell_o = '0;
    unique case (pattern_i)
      PAT_STRIPES: begin
        if (col_u < COL_A)      cell_o = P_CELL_W'(1);
        else if (col_u < COL_B) cell_o = P_CELL_W'(2);
        else                    cell_o = P_CELL_W'(3);
      end
      PAT_CLEAR:    cell_o = '0;
      PAT_CHECKER:  cell_o = (row_u[0] ^ col_u[0]) ? '0 : '1;
      PAT_EXTERNAL: cell_o = seed_status_i[off_u +: P_CELL_W];
      default:      cell_o = '0;
    endcase
  end

endmodule

// File: rtl/life_controller.sv
// Grid controller: seeds the grid, paces generations and hands the
// image to an external evolution engine.
module life_controller
  import life_pkg::*;
#(
  parameter int unsigned P_PARAM_N  = 16,
  parameter int unsigned P_PARAM_M  = 16,
  parameter int unsigned P_CELL_W   = LIFE_CELL_W_DEF,
  parameter int unsigned P_PERIOD_W = 27
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    run_en,
  input  logic                                    step_req,
  input  logic                                    load_req,
  input  logic [1:0]                              load_pattern,
  input  logic [P_PARAM_N*P_PARAM_M*P_CELL_W-1:0] seed_status,
  input  logic [P_PERIOD_W-1:0]                   period,
  input  logic [P_PARAM_N*P_PARAM_M*P_CELL_W-1:0] next_status,
  input  logic                                    evo_done,
  output logic                                    evo_start,
  output logic [P_PARAM_N*P_PARAM_M*P_CELL_W-1:0] status,
  output logic [15:0]                             gen_cnt,
  output logic                                    busy
);

  localparam int unsigned GW = P_PARAM_N * P_PARAM_M * P_CELL_W;
  localparam int unsigned RW = clog2_min1(P_PARAM_M);
  localparam int unsigned CW = clog2_min1(P_PARAM_N);

  life_state_e           state_q, state_d;
  life_pat_e             pat_q, pat_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [P_PERIOD_W-1:0] period_q, period_d;
  logic [P_PERIOD_W-1:0] cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic [GW-1:0]         status_q, status_d;
  logic [15:0]           gen_q, gen_d;

  logic [P_CELL_W-1:0]   seed_cell;
  logic [31:0]           cell_off;
  logic                  enter_load;
  logic                  enter_wait;

  assign cell_off = (32'(row_q) * P_PARAM_N + 32'(col_q)) * P_CELL_W;

  life_seed_gen #(
    .P_PARAM_N (P_PARAM_N),
    .P_PARAM_M (P_PARAM_M),
    .P_CELL_W  (P_CELL_W)
  ) u_seed_gen (
    .row_i         (row_q),
    .col_i         (col_q),
    .pattern_i     (pat_q),
    .seed_status_i (seed_status),
    .cell_o        (seed_cell)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pat_q    <= PAT_STRIPES;
      row_q    <= '0;
      col_q    <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      status_q <= '0;
      gen_q    <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      row_q    <= row_d;
      col_q    <= col_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      status_q <= status_d;
      gen_q    <= gen_d;
    end
  end

  // Next-state logic; LOAD/WAIT entry side effects are shared via flags
  // so every path into those states initialises them identically.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    row_d      = row_q;
    col_d      = col_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    first_d    = 1'b0;
    status_d   = status_q;
    gen_d      = gen_q;
    enter_load = 1'b0;
    enter_wait = 1'b0;

    unique case (state_q)
      ST_IDLE: enter_load = 1'b1;

      ST_LOAD: begin
        status_d[cell_off +: P_CELL_W] = seed_cell;
        if (col_q == CW'(P_PARAM_N - 1)) begin
          col_d = '0;
          if (row_q == RW'(P_PARAM_M - 1)) begin
            row_d      = '0;
            enter_wait = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      ST_WAIT: begin
        if (load_req) begin
          enter_load = 1'b1;
        end else if (run_en) begin
          if (cnt_q == period_q - P_PERIOD_W'(1)) begin
            state_d = ST_CALC;
            first_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (step_req) begin
            state_d = ST_CALC;
            first_d = 1'b1;
          end
        end
      end

      ST_CALC: begin
        if (load_req) begin
          enter_load = 1'b1;
        end else if (evo_done && !first_q) begin
          state_d = ST_UPDATE;
        end
      end

      ST_UPDATE: begin
        if (load_req) begin
          enter_load = 1'b1;
        end else begin
          status_d   = next_status;
          gen_d      = gen_q + 16'd1;
          enter_wait = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (enter_load) begin
      state_d = ST_LOAD;
      pat_d   = life_pat_e'(load_pattern);
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
      gen_d   = '0;
    end

    if (enter_wait) begin
      state_d  = ST_WAIT;
      period_d = (period == '0) ? P_PERIOD_W'(1) : period;
      cnt_d    = '0;
    end
  end

  assign evo_start = (state_q == ST_CALC) && first_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_CALC) || (state_q == ST_UPDATE);
  assign status    = status_q;
  assign gen_cnt   = gen_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller on a 4x4 grid of 2-bit cells.
module tb_life_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        step_req;
  logic        load_req;
  logic [1:0]  load_pattern;
  logic [31:0] seed_status;
  logic [7:0]  period;
  logic [31:0] next_status;
  logic        evo_done;
  logic        evo_start;
  logic [31:0] status;
  logic [15:0] gen_cnt;
  logic        busy;

  logic        eng_auto;
  logic        eng_done;
  logic [1:0]  eng_cnt;
  logic        evo_done_man;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  int unsigned starts[$];
  int unsigned gens[$];
  int unsigned n;

  localparam logic [31:0] IMG_STRIPES = 32'hF9F9_F9F9;
  localparam logic [31:0] IMG_CHECKER = 32'hCC33_CC33;

  life_controller #(
    .P_PARAM_N  (4),
    .P_PARAM_M  (4),
    .P_CELL_W   (2),
    .P_PERIOD_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .step_req     (step_req),
    .load_req     (load_req),
    .load_pattern (load_pattern),
    .seed_status  (seed_status),
    .period       (period),
    .next_status  (next_status),
    .evo_done     (evo_done),
    .evo_start    (evo_start),
    .status       (status),
    .gen_cnt      (gen_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Engine model: result valid for one cycle, two cycles after the start pulse.
  always @(posedge clk) begin
    if (!eng_auto) begin
      eng_cnt  <= 2'd0;
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (evo_start) begin
        eng_cnt <= 2'd1;
      end else if (eng_cnt == 2'd1) begin
        eng_cnt  <= 2'd0;
        eng_done <= 1'b1;
      end
    end
  end

  assign evo_done = eng_auto ? eng_done : evo_done_man;

  // Start-pulse log: cycle stamp and generation count at each pulse.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (evo_start === 1'b1) begin
      starts.push_back(cyc);
      gens.push_back(32'(gen_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive busy samples, starting with the current one.
  task automatic count_busy(output int unsigned cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 60) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    run_en       = 1'b0;
    step_req     = 1'b0;
    load_req     = 1'b0;
    load_pattern = 2'd0;
    seed_status  = '0;
    period       = 8'd3;
    next_status  = '0;
    eng_auto     = 1'b1;
    evo_done_man = 1'b0;

    #2;
    check("rst_status", status, 32'h0);
    check("rst_gen", 32'(gen_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(evo_start), 32'd0);

    // Initial stripes load; pattern change mid-load must be ignored.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("idle_busy", 32'(busy), 32'd0);
    tick();
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      if (n == 3) load_pattern = 2'd1;
      tick();
    end
    check("load_len_stripes", n, 32'd16);
    check("img_stripes", status, IMG_STRIPES);
    check("gen_after_load", 32'(gen_cnt), 32'd0);

    // Paused: no starts, then a single step.
    next_status = 32'h1B1B_2C2C;
    repeat (100) tick();
    check("paused_no_start", starts.size(), 32'd0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_start", 32'(evo_start), 32'd1);
    tick();
    check("start_one_cycle", 32'(evo_start), 32'd0);
    count_busy(n);
    check("step_done", 32'(busy), 32'd0);
    repeat (20) tick();
    check("step_count", starts.size(), 32'd1);
    check("step_gen", 32'(gen_cnt), 32'd1);
    check("step_img", status, 32'h1B1B_2C2C);

    // Reload from WAIT with checkerboard.
    load_req     = 1'b1;
    load_pattern = 2'd2;
    tick();
    load_req = 1'b0;
    check("reload_busy", 32'(busy), 32'd1);
    check("reload_gen", 32'(gen_cnt), 32'd0);
    count_busy(n);
    check("load_len_checker", n, 32'd16);
    check("img_checker", status, IMG_CHECKER);

    // Free run, period 3: starts 7 cycles apart.
    next_status = 32'h5A5A_C3C3;
    starts.delete();
    gens.delete();
    run_en = 1'b1;
    n = 0;
    while (starts.size() < 4 && n < 200) begin
      n++;
      tick();
    end
    run_en = 1'b0;
    check("run_starts", starts.size(), 32'd4);
    for (int i = 0; i + 1 < starts.size(); i++) begin
      check("run_spacing", starts[i+1] - starts[i], 32'd7);
      check("run_gen", gens[i+1], 32'(i + 1));
    end
    count_busy(n);
    check("run_gen_final", 32'(gen_cnt), 32'd4);
    check("run_img", status, 32'h5A5A_C3C3);

    // Period 0 behaves as 1: start on the cycle after WAIT entry.
    period = 8'd0;
    starts.delete();
    run_en = 1'b1;
    n = 0;
    while (starts.size() < 3 && n < 100) begin
      n++;
      tick();
    end
    run_en = 1'b0;
    check("p0_starts", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      check("p0_spacing1", starts[1] - starts[0], 32'd5);
      check("p0_spacing2", starts[2] - starts[1], 32'd5);
    end
    count_busy(n);
    check("p0_gen", 32'(gen_cnt), 32'd7);

    // Load request during CALC discards the pending result.
    period       = 8'd3;
    eng_auto     = 1'b0;
    next_status  = 32'hFFFF_FFFF;
    starts.delete();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("calc_start", 32'(evo_start), 32'd1);
    tick();
    load_req     = 1'b1;
    load_pattern = 2'd1;
    tick();
    load_req     = 1'b0;
    evo_done_man = 1'b1;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_gen", 32'(gen_cnt), 32'd0);
    count_busy(n);
    check("load_len_clear", n, 32'd16);
    check("abort_img", status, 32'h0);
    repeat (5) tick();
    check("abort_img_hold", status, 32'h0);
    check("abort_gen_hold", 32'(gen_cnt), 32'd0);
    check("abort_starts", starts.size(), 32'd1);
    evo_done_man = 1'b0;

    // Load and step together: load wins; external seed.
    starts.delete();
    load_req     = 1'b1;
    step_req     = 1'b1;
    load_pattern = 2'd3;
    seed_status  = 32'hA5A5_A5A5;
    tick();
    load_req = 1'b0;
    step_req = 1'b0;
    check("collide_no_start", 32'(evo_start), 32'd0);
    check("collide_busy", 32'(busy), 32'd1);
    count_busy(n);
    check("load_len_ext", n, 32'd16);
    check("img_external", status, 32'hA5A5_A5A5);
    repeat (10) tick();
    check("collide_starts", starts.size(), 32'd0);

    // Async reset mid-CALC; late evo_done must be ignored afterwards.
    load_pattern = 2'd0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("rst_calc_start", 32'(evo_start), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_start", 32'(evo_start), 32'd0);
    check("arst_status", status, 32'h0);
    check("arst_gen", 32'(gen_cnt), 32'd0);
    tick();
    rst_n        = 1'b1;
    evo_done_man = 1'b1;
    tick();
    count_busy(n);
    check("load_len_after_rst", n, 32'd16);
    check("img_after_rst", status, IMG_STRIPES);
    repeat (5) tick();
    check("late_done_gen", 32'(gen_cnt), 32'd0);
    check("late_done_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
